bitonic_merge_stream: RTL and testbench
=======================================

# bitonic_merge_stream

Pipelined, flow-controlled bitonic merger that sorts one bitonic vector of SIZE keys per beat into ascending or descending order. Each beat selects its own direction and optionally carries a per-element payload. It is the streaming successor to the fixed-direction, free-running merger. It sits between the bitonic pre-sort stages and the downstream consumer, which may stall.

## Interface
- VALUE_BITS, 8, key width in bits
- DEPTH, 3, number of merge stages (≥1); SIZE = 1<<DEPTH elements per beat
- PAYLOAD_BITS, 4, per-element payload width (used only with payload enabled)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage 0 can accept
- in_dir  in  1  0 ascending, 1 descending, for this beat
- in_keys  in  SIZE×VALUE_BITS  bitonic key vector, element i at [i]
- in_payload  in  SIZE×PAYLOAD_BITS  per-element payload (payload builds only)
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts
- out_dir  out  1  direction of the output beat
- out_keys  out  SIZE×VALUE_BITS  sorted keys
- out_payload  out  SIZE×PAYLOAD_BITS  payload permuted with keys (payload builds only)

## Operation
- DEPTH registered stages, 0..DEPTH-1. Each stage holds a valid bit, dir, keys and payload.
- Stage s works in blocks of B = SIZE>>s and compares element j with j+B/2 for each block and each j < B/2.
- Ascending: swap only if key[j] > key[j+B/2]. Descending: swap only if key[j] < key[j+B/2]. Equal keys never swap.
- Payload moves with its key on every swap.
- Stage k loads when it is empty, or when its contents advance this cycle. Stage DEPTH-1 advances on out_ready. Stage k<DEPTH-1 advances when stage k+1 loads. This pipeline collapses bubbles.
- in_ready = stage 0 empty, or stage 0 advancing. Input transfer happens on in_valid && in_ready.
- out_valid = valid bit of stage DEPTH-1. out_keys, out_payload and out_dir come directly from the last stage's registers.
- Output holds stable while out_valid && !out_ready.
- Input that is not bitonic produces a deterministic but unsorted result. This is not flagged.

## Timing
- Reset: all valid bits 0, out_valid 0, in_ready 1, out_dir 0, out_keys 0, out_payload 0. All data registers clear to 0.
- Latency: a beat accepted at edge t is presented on out_valid after edge t+DEPTH-1, when there is no stall.
- Throughput: 1 beat/cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0 and nothing moves.
- Full pipeline with out_ready=1: in_ready=1 in the same cycle, and a simultaneous in/out transfer keeps the pipeline full.
- in_ready depends combinationally on out_ready (the ready chain). Accepted cost: one ready path of DEPTH levels.
- Reset asserted mid-operation: all beats in flight are discarded at once, asynchronously. There is no partial output.

## Configuration
- MERGE_PAYLOAD_EN defined: payload ports and registers exist and payload follows keys.
- MERGE_PAYLOAD_EN undefined: in_payload and out_payload ports are absent, there is no payload storage, and PAYLOAD_BITS is ignored. Key behaviour and timing are identical in both builds.

## Structure
- Package merge_pkg: direction enum (MERGE_ASC=0, MERGE_DESC=1) and a function computing partner index and block size from stage index and DEPTH.
- Sub-module merge_stage: one registered compare-exchange stage with its valid bit and load/advance logic, parametrised by stage index.
- The top instantiates DEPTH merge_stage instances in a generate loop and wires the ready chain.

## Test plan
- DEPTH=3, in_dir=0, keys {1,4,6,7,5,3,2,0} (index 0 first) → {0,1,2,3,4,5,6,7}, out_valid exactly 2 cycles after acceptance.
- Same keys, in_dir=1 → {7,6,5,4,3,2,1,0}, out_dir=1.
- Payload build, ascending keys {5,5,9,2,...} with payload = element index → equal keys keep input order of their payloads, and every payload stays bound to its original key.
- Back-to-back beats with alternating direction and out_ready=1 → one output per cycle in order, each sorted in its own direction.
- Fill the pipeline, hold out_ready=0 for 5 cycles → in_ready=0, out_keys stable. Release → 3 beats drain in order with no loss or duplication.
- Assert rst_n low with 2 beats in flight → out_valid=0 and out_keys=0 immediately. After release, in_ready=1 and the next beat has normal latency.

Source files
------------

// File: rtl/merge_pkg.sv
// ---------------------------------------------------------------------------
// merge_pkg : direction encoding and compare-exchange index helper
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package merge_pkg;

  typedef enum logic {
    MERGE_ASC  = 1'b0,
    MERGE_DESC = 1'b1
  } merge_dir_e;

  typedef struct packed {
    int unsigned block;
    int unsigned partner;
  } merge_idx_t;

  // Stage s compares inside blocks of (1<<depth)>>s elements; the partner
  // sits half a block away, so it is simply the element index with that bit flipped.
  function automatic merge_idx_t merge_idx(input int unsigned stage,
                                           input int unsigned depth,
                                           input int unsigned elem);
    merge_idx_t r;
    r.block   = (32'd1 << depth) >> stage;
    r.partner = elem ^ (r.block >> 1);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/merge_stage.sv
// ---------------------------------------------------------------------------
// merge_stage : one registered compare-exchange stage with valid/load logic
//               (payload storage only when MERGE_PAYLOAD_EN is defined)
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module merge_stage
  import merge_pkg::*;
#(
  parameter int VALUE_BITS = 8,
  parameter int DEPTH      = 3,
  parameter int STAGE      = 0
`ifdef MERGE_PAYLOAD_EN
  , parameter int PAYLOAD_BITS = 4
`endif
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  input  logic                                      in_dir,
  input  logic [(1<<DEPTH)-1:0][VALUE_BITS-1:0]     in_keys,
  input  logic                                      adv,
  output logic                                      load,
  output logic                                      out_valid,
  output logic                                      out_dir,
  output logic [(1<<DEPTH)-1:0][VALUE_BITS-1:0]     out_keys
`ifdef MERGE_PAYLOAD_EN
  , input  logic [(1<<DEPTH)-1:0][PAYLOAD_BITS-1:0] in_payload,
  output logic [(1<<DEPTH)-1:0][PAYLOAD_BITS-1:0]   out_payload
`endif
);

  localparam int SIZE = 1 << DEPTH;

  logic                             valid_q, valid_d;
  logic                             dir_q, dir_d;
  logic [SIZE-1:0][VALUE_BITS-1:0]  keys_q, keys_d, keys_x;
  logic                             desc;
`ifdef MERGE_PAYLOAD_EN
  logic [SIZE-1:0][PAYLOAD_BITS-1:0] pay_q, pay_d, pay_x;
`endif

  assign desc = (merge_dir_e'(in_dir) == MERGE_DESC);
  assign load = !valid_q || adv;

  // Both members of a pair evaluate the same lo/hi comparison, so they agree on the swap.
  for (genvar i = 0; i < SIZE; i++) begin : g_cx
    localparam merge_idx_t  IDX     = merge_idx(STAGE, DEPTH, i);
    localparam int unsigned PARTNER = IDX.partner;
    localparam bit          LOWER   = (i % IDX.block) < (IDX.block >> 1);
    localparam int unsigned LO      = LOWER ? i : PARTNER;
    localparam int unsigned HI      = LOWER ? PARTNER : i;

    logic swap;
    assign swap      = desc ? (in_keys[LO] < in_keys[HI]) : (in_keys[LO] > in_keys[HI]);
    assign keys_x[i] = swap ? in_keys[PARTNER] : in_keys[i];
`ifdef MERGE_PAYLOAD_EN
    assign pay_x[i]  = swap ? in_payload[PARTNER] : in_payload[i];
`endif
  end

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    keys_d  = keys_q;
`ifdef MERGE_PAYLOAD_EN
    pay_d   = pay_q;
`endif
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        dir_d  = in_dir;
        keys_d = keys_x;
`ifdef MERGE_PAYLOAD_EN
        pay_d  = pay_x;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      keys_q  <= '0;
`ifdef MERGE_PAYLOAD_EN
      pay_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      keys_q  <= keys_d;
`ifdef MERGE_PAYLOAD_EN
      pay_q   <= pay_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_dir   = dir_q;
  assign out_keys  = keys_q;
`ifdef MERGE_PAYLOAD_EN
  assign out_payload = pay_q;
`endif

endmodule

`default_nettype wire

// File: rtl/bitonic_merge_stream.sv
// ---------------------------------------------------------------------------
// bitonic_merge_stream : flow-controlled DEPTH-stage bitonic merger, per-beat
//                        direction; MERGE_PAYLOAD_EN adds a per-element payload
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bitonic_merge_stream
  import merge_pkg::*;
#(
  parameter int VALUE_BITS   = 8,
  parameter int DEPTH        = 3,
  parameter int PAYLOAD_BITS = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      in_dir,
  input  logic [(1<<DEPTH)-1:0][VALUE_BITS-1:0]     in_keys,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_dir,
  output logic [(1<<DEPTH)-1:0][VALUE_BITS-1:0]     out_keys
`ifdef MERGE_PAYLOAD_EN
  , input  logic [(1<<DEPTH)-1:0][PAYLOAD_BITS-1:0] in_payload,
  output logic [(1<<DEPTH)-1:0][PAYLOAD_BITS-1:0]   out_payload
`endif
);

  localparam int SIZE = 1 << DEPTH;

  if (DEPTH < 1 || VALUE_BITS < 1 || PAYLOAD_BITS < 1) begin : g_bad_params
    $error("bitonic_merge_stream: DEPTH, VALUE_BITS and PAYLOAD_BITS must be >= 1");
  end

  // Each stage's load doubles as the upstream stage's advance: this is the ready chain.
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic                             up_valid, up_dir, adv;
    logic                             load_w, valid_w, dir_w;
    logic [SIZE-1:0][VALUE_BITS-1:0]  up_keys, keys_w;
`ifdef MERGE_PAYLOAD_EN
    logic [SIZE-1:0][PAYLOAD_BITS-1:0] up_pay, pay_w;
`endif

    if (s == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_dir   = in_dir;
      assign up_keys  = in_keys;
`ifdef MERGE_PAYLOAD_EN
      assign up_pay   = in_payload;
`endif
    end else begin : g_link
      assign up_valid = g_stage[s-1].valid_w;
      assign up_dir   = g_stage[s-1].dir_w;
      assign up_keys  = g_stage[s-1].keys_w;
`ifdef MERGE_PAYLOAD_EN
      assign up_pay   = g_stage[s-1].pay_w;
`endif
    end

    if (s == DEPTH - 1) begin : g_tail
      assign adv = out_ready;
    end else begin : g_next
      assign adv = g_stage[s+1].load_w;
    end

    merge_stage #(
      .VALUE_BITS   (VALUE_BITS),
      .DEPTH        (DEPTH),
      .STAGE        (s)
`ifdef MERGE_PAYLOAD_EN
      , .PAYLOAD_BITS (PAYLOAD_BITS)
`endif
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (up_valid),
      .in_dir     (up_dir),
      .in_keys    (up_keys),
      .adv        (adv),
      .load       (load_w),
      .out_valid  (valid_w),
      .out_dir    (dir_w),
      .out_keys   (keys_w)
`ifdef MERGE_PAYLOAD_EN
      , .in_payload  (up_pay),
      .out_payload (pay_w)
`endif
    );
  end

  assign in_ready  = g_stage[0].load_w;
  assign out_valid = g_stage[DEPTH-1].valid_w;
  assign out_dir   = g_stage[DEPTH-1].dir_w;
  assign out_keys  = g_stage[DEPTH-1].keys_w;
`ifdef MERGE_PAYLOAD_EN
  assign out_payload = g_stage[DEPTH-1].pay_w;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitonic_merge_stream.sv
// ---------------------------------------------------------------------------
// tb_bitonic_merge_stream : scoreboard bench for bitonic_merge_stream
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bitonic_merge_stream;

  localparam int VB = 8;
  localparam int D  = 3;
  localparam int SZ = 1 << D;
  localparam int PB = 4;

  typedef logic [SZ-1:0][VB-1:0] keys_t;
  typedef struct {
    logic  dir;
    keys_t keys;
    keys_t src;
    bit    stable;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  in_valid = 1'b0;
  logic  in_ready;
  logic  in_dir = 1'b0;
  keys_t in_keys = '0;
  logic  out_valid;
  logic  out_ready = 1'b0;
  logic  out_dir;
  keys_t out_keys;
`ifdef MERGE_PAYLOAD_EN
  logic [SZ-1:0][PB-1:0] in_payload;
  logic [SZ-1:0][PB-1:0] out_payload;
`endif

  int   n_vec = 0;
  int   n_miscmp = 0;
  int   n_out = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  bitonic_merge_stream #(
    .VALUE_BITS   (VB),
    .DEPTH        (D),
    .PAYLOAD_BITS (PB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_keys   (in_keys),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dir   (out_dir),
    .out_keys  (out_keys)
`ifdef MERGE_PAYLOAD_EN
    , .in_payload  (in_payload),
    .out_payload (out_payload)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic keys_t sort_keys(input keys_t k, input logic desc);
    keys_t         r;
    logic [VB-1:0] t;
    r = k;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ - 1 - i; j++)
        if (desc ? (r[j] < r[j+1]) : (r[j] > r[j+1])) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  // Rising run from the front, falling run from the back: always bitonic.
  function automatic keys_t rand_bitonic();
    keys_t s, r;
    int    f, b;
    f = 0;
    b = SZ - 1;
    r = '0;
    for (int i = 0; i < SZ; i++) s[i] = VB'($urandom_range(0, 255));
    s = sort_keys(s, 1'b0);
    for (int i = 0; i < SZ; i++) begin
      if ($urandom_range(0, 1) == 1) begin r[f] = s[i]; f++; end
      else begin r[b] = s[i]; b--; end
    end
    return r;
  endfunction

  task automatic send(input logic d, input keys_t k, input bit stable);
    exp_t e;
    int   waited;
    waited   = 0;
    in_valid = 1'b1;
    in_dir   = d;
    in_keys  = k;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.dir = d; e.keys = sort_keys(k, d); e.src = k; e.stable = stable;
        exp_q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 50) begin
        check_value("in_ready_timeout", 64'(in_ready), 64'(1));
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check_value(tag, 64'(n), 64'(D - 1));
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check_value(tag, 64'(exp_q.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check_value("sb_underflow", 64'(exp_q.size()), 64'(1));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_value("out_keys", 64'(out_keys), 64'(e.keys));
        check_value("out_dir", 64'(out_dir), 64'(e.dir));
`ifdef MERGE_PAYLOAD_EN
        begin
          logic [SZ-1:0] seen;
          int            p;
          seen = '0;
          for (int i = 0; i < SZ; i++) begin
            p = int'(out_payload[i]);
            seen[p] = 1'b1;
            check_value("pay_bind", 64'(out_keys[i]), 64'(e.src[p]));
          end
          check_value("pay_perm", 64'(seen), 64'({SZ{1'b1}}));
          if (e.stable)
            for (int i = 1; i < SZ; i++)
              if (out_keys[i] == out_keys[i-1])
                check_value("pay_stable", 64'(out_payload[i] > out_payload[i-1]), 64'(1));
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", n_miscmp);
    $fatal(1, "watchdog");
  end

  initial begin
    keys_t vec_a, vec_p, held;
    int    t0, n0;
    // Element 0 is the least significant byte: {1,4,6,7,5,3,2,0}
    vec_a = {8'd0, 8'd2, 8'd3, 8'd5, 8'd7, 8'd6, 8'd4, 8'd1};
    // {5,5,9,2,1,1,0,0}
    vec_p = {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd9, 8'd5, 8'd5};
`ifdef MERGE_PAYLOAD_EN
    for (int i = 0; i < SZ; i++) in_payload[i] = PB'(i);
`endif

    #1;
    check_value("rst_out_valid", 64'(out_valid), 64'(0));
    check_value("rst_in_ready", 64'(in_ready), 64'(1));
    check_value("rst_out_dir", 64'(out_dir), 64'(0));
    check_value("rst_out_keys", 64'(out_keys), 64'(0));
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    send(1'b0, vec_a, 1'b0);
    check_latency("latency_asc");
    wait_drain("drain_asc");
    send(1'b1, vec_a, 1'b0);
    check_latency("latency_desc");
    wait_drain("drain_desc");
`ifdef MERGE_PAYLOAD_EN
    send(1'b0, vec_p, 1'b1);
    wait_drain("drain_payload");
`endif
    send(1'b1, vec_p, 1'b0);
    wait_drain("drain_dup_desc");

    // back-to-back, alternating direction
    t0 = cyc;
    n0 = n_out;
    for (int k = 0; k < 8; k++) send(k[0], rand_bitonic(), 1'b0);
    check_value("b2b_cycles", 64'(cyc - t0), 64'(8));
    wait_drain("drain_b2b");
    check_value("b2b_count", 64'(n_out - n0), 64'(8));

    // fill, stall, then release while pushing more
    out_ready = 1'b0;
    n0 = n_out;
    for (int k = 0; k < 3; k++) send(1'($urandom_range(0, 1)), rand_bitonic(), 1'b0);
    @(negedge clk);
    check_value("full_in_ready", 64'(in_ready), 64'(0));
    check_value("full_out_valid", 64'(out_valid), 64'(1));
    held = out_keys;
    repeat (5) begin
      @(negedge clk);
      check_value("stall_keys", 64'(out_keys), 64'(held));
      check_value("stall_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 2; k++) send(1'($urandom_range(0, 1)), rand_bitonic(), 1'b0);
    check_value("full_pass_cycles", 64'(cyc - t0), 64'(2));
    wait_drain("drain_stall");
    check_value("stall_count", 64'(n_out - n0), 64'(5));

    // asynchronous reset with beats in flight
    out_ready = 1'b0;
    send(1'b0, rand_bitonic(), 1'b0);
    send(1'b1, rand_bitonic(), 1'b0);
    @(posedge clk); #1;
    check_value("pre_rst_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check_value("arst_out_valid", 64'(out_valid), 64'(0));
    check_value("arst_out_keys", 64'(out_keys), 64'(0));
    check_value("arst_out_dir", 64'(out_dir), 64'(0));
    exp_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check_value("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    send(1'b0, vec_a, 1'b0);
    check_latency("latency_post_rst");
    wait_drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

`default_nettype wire
